out_port_fifo: RTL and testbench
================================

// Module: out_port_fifo
// PURPOSE
//  Output-port stage directly downstream of the processor core. Captures every OUT-instruction
//  write (the core's 16-bit out value qualified by the output-write strobe), queues it in a
//  small FIFO, and drains it to an external device over a valid/ready handshake.
//  Back-pressures the pipeline through a registered stall. Keeps a sticky overflow flag and
//  the last value written, for the board display.
// PARAMETERS
//  DATA_W     16  width of one output word
//  DEPTH      4   FIFO entries; power of two, >= 2
//  AFULL_LVL  3   occupancy at or above which o_stall is asserted; 1..DEPTH
//  ADDR_W     2   log2(DEPTH); derived as a localparam, never overridden
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  i_wr        in   1       output-write strobe from the core; one word per cycle while high
//  i_data      in   DATA_W  word to output, sampled when i_wr=1
//  o_stall     out  1       registered; count >= AFULL_LVL; the pipeline holds OUT instructions
//  o_valid     out  1       head word present on o_data
//  o_data      out  DATA_W  head-of-FIFO word
//  i_ready     in   1       external device accepts o_data this cycle
//  o_count     out  ADDR_W+1  current occupancy 0..DEPTH
//  o_last      out  DATA_W  last word accepted into the FIFO (display shadow)
//  o_ovf       out  1       sticky: a write was dropped because the FIFO was full
//  i_ovf_clr   in   1       synchronous clear of o_ovf
// BEHAVIOUR
//  Reset (rst=0, async): pointers=0, count=0, o_valid=0, o_data=0, o_stall=0, o_last=0,
//   o_ovf=0, FSM=EMPTY. Memory contents are not reset.
//  push = i_wr & (count<DEPTH | pop).  pop = o_valid & i_ready.
//  Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
//   Pointers wrap modulo DEPTH by natural ADDR_W overflow.
//  count_next = count + push - pop. Simultaneous push and pop leave count unchanged.
//  Full case: a write on a full FIFO with a same-cycle pop is accepted. A write on a full
//   FIFO without a pop is dropped, o_ovf<=1, and o_last is unchanged.
//  o_last <= i_data on every accepted push.
//  o_ovf: i_ovf_clr has priority over a same-cycle set, so clear wins.
//  Output is first-word-fall-through:
//   - o_data = mem[rd_ptr] whenever o_valid=1.
//   - A word pushed into an empty FIFO appears on o_valid/o_data the next cycle (latency 1).
//   - No bypass in the push cycle.
//  Handshake: once o_valid=1, o_data is held stable until the pop. A device may hold
//   i_ready high permanently; the drain rate is then 1 word/cycle.
//  FSM (3 states, registered):
//   EMPTY  count==0.
//          push -> ACTIVE.
//   ACTIVE 0<count<DEPTH.
//          count_next==0 -> EMPTY; count_next==DEPTH -> FULL; otherwise stay.
//   FULL   count==DEPTH.
//          pop (with or without push) -> ACTIVE if count_next<DEPTH, else stay.
//  o_valid = (state!=EMPTY).
//  o_stall is registered from count_next >= AFULL_LVL, so it tracks occupancy with
//   1-cycle latency. With AFULL_LVL=DEPTH-1 the one in-flight write always fits.
//  i_wr with i_data=X is not allowed. X on i_ready while o_valid=0 is don't-care.
//  Reset asserted mid-transfer discards all queued words. o_valid drops immediately (async).
// STRUCTURE
//  Shared package out_port_pkg: OUT_DATA_W=16, OUT_FIFO_DEPTH=4, and the typedef of the
//   FSM state enum {EMPTY, ACTIVE, FULL}.
//  One sub-module, out_port_mem:
//   - DEPTH x DATA_W register file, one synchronous write port.
//   - One asynchronous read port (rd_addr -> rd_data), no reset.
//  Top level holds pointers, count, FSM, stall, overflow and last-value logic.
// TESTING
//  1 Reset: drive rst=0 mid-run with 3 words queued
//     -> o_valid=0, o_count=0, o_ovf=0, o_last=0 asynchronously; no word emitted after release.
//  2 Ordering: i_ready=0; push 0x0011, 0x0022, 0x0033; then i_ready=1
//     -> o_data sequence 0x0011, 0x0022, 0x0033 on consecutive cycles; count 3,2,1,0; o_last=0x0033.
//  3 Overflow: i_ready=0; push 0xA000..0xA004 (5 words)
//     -> count=4, FSM=FULL, o_ovf=1, o_last=0xA003; drain yields 0xA000..0xA003 only;
//        i_ovf_clr=1 then clears o_ovf.
//  4 Full with simultaneous pop: count=4, i_wr=1 data 0xBEEF, i_ready=1
//     -> word accepted, count stays 4, o_ovf stays 0; 0xBEEF is the 4th word drained afterwards.
//  5 Stall threshold: AFULL_LVL=3; push 3 words with i_ready=0
//     -> o_stall rises the cycle after the 3rd push; one pop -> o_stall falls the next cycle.
//  6 Streaming: i_ready=1 throughout; i_wr=1 for 8 cycles with data 1..8
//     -> each word is output one cycle after its push; count never exceeds 1; o_stall never asserts.

Source files
------------

// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared constants and FSM state type for the output-port FIFO
package out_port_pkg;

    localparam int OUT_DATA_W     = 16;
    localparam int OUT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/out_port_mem.sv
// rtl/out_port_mem.sv - register file with one synchronous write port and one asynchronous read port
module out_port_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - OUT-instruction capture FIFO with valid/ready drain, registered stall and overflow flag
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int DATA_W    = OUT_DATA_W,
    parameter int DEPTH     = OUT_FIFO_DEPTH,
    parameter int AFULL_LVL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_stall,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [DATA_W-1:0]          o_last,
    output logic                       o_ovf,
    input  logic                       i_ovf_clr
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] rd_data;
    logic              push;
    logic              pop;
    fifo_state_t       state;
    fifo_state_t       state_next;

    out_port_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign o_valid = (state != EMPTY);
    assign o_data  = o_valid ? rd_data : '0;
    assign o_count = count;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    always_comb begin
        pop  = o_valid & i_ready;
        push = i_wr & ((count < DEPTH_CNT) | pop);
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (push) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (count_next == '0)            state_next = EMPTY;
                else if (count_next == DEPTH_CNT) state_next = FULL;
            end
            FULL: begin
                if (pop && (count_next < DEPTH_CNT)) state_next = ACTIVE;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_stall <= 1'b0;
            o_last  <= '0;
            o_ovf   <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            o_stall <= (count_next >= AFULL_CNT);
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                o_last <= i_data;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (i_ovf_clr) begin
                o_ovf <= 1'b0;
            end else if (i_wr && !push) begin
                o_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - scoreboard bench for out_port_fifo
module tb_out_port_fifo;
    import out_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_wr = 1'b0;
    logic [15:0] i_data = 16'h0;
    logic        i_ready = 1'b0;
    logic        i_ovf_clr = 1'b0;
    logic        o_stall;
    logic        o_valid;
    logic [15:0] o_data;
    logic [2:0]  o_count;
    logic [15:0] o_last;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_q[$];
    logic [15:0] drained[$];
    logic [15:0] exp_q[$];
    logic [15:0] m_last = 16'h0;
    logic        m_ovf = 1'b0;
    logic        m_stall = 1'b0;
    logic        m_push;
    logic        m_pop;
    bit          stream = 1'b0;
    bit          stall_seen = 1'b0;
    int          max_cnt = 0;

    out_port_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (i_wr),
        .i_data    (i_data),
        .o_stall   (o_stall),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_count   (o_count),
        .o_last    (o_last),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic wr, input logic [15:0] d, input logic rdy, input logic clr);
        @(posedge clk);
        #2;
        i_wr      = wr;
        i_data    = d;
        i_ready   = rdy;
        i_ovf_clr = clr;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_n"}, 32'(drained.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq(tag, (i < drained.size()) ? 32'(drained[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    // Reference model: compare outputs, then predict the next edge's effect.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            m_last  = 16'h0;
            m_ovf   = 1'b0;
            m_stall = 1'b0;
        end else begin
            check_eq("count", 32'(o_count), 32'(sb_q.size()));
            check_eq("valid", 32'(o_valid), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) check_eq("data", 32'(o_data), 32'(sb_q[0]));
            check_eq("last", 32'(o_last), 32'(m_last));
            check_eq("ovf", 32'(o_ovf), 32'(m_ovf));
            check_eq("stall", 32'(o_stall), 32'(m_stall));
            if (stream) begin
                if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
                if (o_stall) stall_seen = 1'b1;
            end
            m_pop  = (sb_q.size() != 0) && i_ready;
            m_push = i_wr && ((sb_q.size() < 4) || m_pop);
            if (m_pop) begin
                drained.push_back(o_data);
                void'(sb_q.pop_front());
            end
            if (m_push) begin
                sb_q.push_back(i_data);
                m_last = i_data;
            end
            if (i_ovf_clr) m_ovf = 1'b0;
            else if (i_wr && !m_push) m_ovf = 1'b1;
            m_stall = (sb_q.size() >= 3);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_count", 32'(o_count), 32'd0);
        check_eq("rst_stall", 32'(o_stall), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        check_eq("rst_last", 32'(o_last), 32'd0);
        check_eq("rst_ovf", 32'(o_ovf), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Async reset with three words queued
        drive(1'b1, 16'h0101, 1'b0, 1'b0);
        drive(1'b1, 16'h0102, 1'b0, 1'b0);
        drive(1'b1, 16'h0103, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        check_eq("t1_pre_count", 32'(o_count), 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("t1_valid", 32'(o_valid), 32'd0);
        check_eq("t1_count", 32'(o_count), 32'd0);
        check_eq("t1_ovf", 32'(o_ovf), 32'd0);
        check_eq("t1_last", 32'(o_last), 32'd0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drained.delete();
        repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);
        at_neg();
        check_eq("t1_no_emit", 32'(drained.size()), 32'd0);

        // Ordering
        drained.delete();
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        drive(1'b1, 16'h0033, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 16'h0, 1'b1, 1'b0);
        at_neg();
        exp_q.delete();
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h0033);
        check_drained("t2_order");
        check_eq("t2_last", 32'(o_last), 32'h0033);
        check_eq("t2_count", 32'(o_count), 32'd0);

        // Overflow
        drained.delete();
        for (int i = 0; i < 5; i++) drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        check_eq("t3_count", 32'(o_count), 32'd4);
        check_eq("t3_state", 32'(dut.state), 32'(FULL));
        check_eq("t3_ovf", 32'(o_ovf), 32'd1);
        check_eq("t3_last", 32'(o_last), 32'hA003);
        repeat (5) drive(1'b0, 16'h0, 1'b1, 1'b0);
        at_neg();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
        check_drained("t3_drain");
        check_eq("t3_ovf_sticky", 32'(o_ovf), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        check_eq("t3_ovf_clr", 32'(o_ovf), 32'd0);

        // Full with simultaneous pop
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        check_eq("t4_count", 32'(o_count), 32'd4);
        check_eq("t4_ovf", 32'(o_ovf), 32'd0);
        check_eq("t4_last", 32'(o_last), 32'hBEEF);
        drained.delete();
        repeat (4) drive(1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        exp_q.delete();
        exp_q.push_back(16'hC002);
        exp_q.push_back(16'hC003);
        exp_q.push_back(16'hC004);
        exp_q.push_back(16'hBEEF);
        check_drained("t4_drain");

        // Stall threshold
        drive(1'b1, 16'h0001, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        drive(1'b1, 16'h0003, 1'b0, 1'b0);
        at_neg();
        check_eq("t5_stall_push3", 32'(o_stall), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        check_eq("t5_stall_rise", 32'(o_stall), 32'd1);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        at_neg();
        check_eq("t5_stall_popcyc", 32'(o_stall), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        check_eq("t5_stall_fall", 32'(o_stall), 32'd0);
        repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);

        // Streaming
        drained.delete();
        max_cnt = 0;
        stall_seen = 1'b0;
        stream = 1'b1;
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        at_neg();
        stream = 1'b0;
        check_eq("t6_maxcnt", 32'(max_cnt), 32'd1);
        check_eq("t6_stall", 32'(stall_seen), 32'd0);
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
        check_drained("t6_stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
